// File: rtl/byte_mem_pkg.sv
// Shared types and default geometry for the byte-addressed 2-read/1-write memory.
// Optional same-edge write-to-read bypass is selected with macro BYTE_MEM_BYPASS_EN.
package byte_mem_pkg;

   localparam int DEFAULT_B  = 8;
   localparam int DEFAULT_N  = 10;
   localparam int DEFAULT_WB = 4;

   typedef enum logic {
      CLEAR,
      READY
   } state_t;

endpackage

// File: rtl/byte_mem_if.sv
// Bus bundle for byte_mem_2r1w: clear control, two read ports and one byte-enabled write port.
interface byte_mem_if
   import byte_mem_pkg::*;
#(
   parameter int B  = DEFAULT_B,
   parameter int N  = DEFAULT_N,
   parameter int WB = DEFAULT_WB
) ();

   logic            clr_req;
   logic            busy;
   logic            r_en1;
   logic [N-1:0]    r_addr1;
   logic [WB*B-1:0] r_data1;
   logic            r_valid1;
   logic            r_en2;
   logic [N-1:0]    r_addr2;
   logic [WB*B-1:0] r_data2;
   logic            r_valid2;
   logic            w_en;
   logic [N-1:0]    w_addr;
   logic [WB*B-1:0] w_data;
   logic [WB-1:0]   w_be;

   modport master (
      output clr_req, r_en1, r_addr1, r_en2, r_addr2, w_en, w_addr, w_data, w_be,
      input  busy, r_data1, r_valid1, r_data2, r_valid2
   );

   modport slave (
      input  clr_req, r_en1, r_addr1, r_en2, r_addr2, w_en, w_addr, w_data, w_be,
      output busy, r_data1, r_valid1, r_data2, r_valid2
   );

endinterface

// File: rtl/byte_mem_rd_port.sv
// One read port: maps a byte address onto the WB byte banks, reassembles a big-endian word
// and registers it. BYTE_MEM_BYPASS_EN merges same-edge written bytes into the result.
module byte_mem_rd_port
   import byte_mem_pkg::*;
#(
   parameter int B  = DEFAULT_B,
   parameter int N  = DEFAULT_N,
   parameter int WB = DEFAULT_WB
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                active,
   input  logic                                r_en,
   input  logic [N-1:0]                        r_addr,
   output logic [WB-1:0][N-$clog2(WB)-1:0]     bank_row,
   input  logic [WB-1:0][B-1:0]                bank_rdata,
   input  logic                                wr_ok,
   input  logic [N-1:0]                        w_addr,
   input  logic [WB*B-1:0]                     w_data,
   input  logic [WB-1:0]                       w_be,
   output logic [WB*B-1:0]                     r_data,
   output logic                                r_valid
);

   localparam int WL = $clog2(WB);
   localparam int RW = N - WL;

   logic [WB-1:0][B-1:0] word;
   logic [WB*B-1:0]      r_data_reg;
   logic                 r_valid_reg;

   genvar gi;
   generate
      for (gi = 0; gi < WB; gi++) begin : g_bank
         // Bank gi lands in the next row when the start offset has already passed it.
         assign bank_row[gi] = r_addr[N-1:WL] + RW'(WL'(gi) < r_addr[WL-1:0]);
      end

      for (gi = 0; gi < WB; gi++) begin : g_byte
         logic [WL-1:0] sel;
         logic [B-1:0]  old_byte;
         assign sel      = r_addr[WL-1:0] + WL'(gi);
         assign old_byte = bank_rdata[sel];
`ifdef BYTE_MEM_BYPASS_EN
         logic [WB-1:0][B-1:0] w_bytes;
         logic [N-1:0]         dist;
         logic [WL-1:0]        lane;
         logic                 hit;
         assign w_bytes = w_data;
         assign dist    = r_addr + N'(gi) - w_addr;
         assign lane    = ~dist[WL-1:0];
         assign hit     = wr_ok && (dist < N'(WB)) && w_be[lane];
         assign word[WB-1-gi] = hit ? w_bytes[lane] : old_byte;
`else
         assign word[WB-1-gi] = old_byte;
`endif
      end
   endgenerate

`ifndef BYTE_MEM_BYPASS_EN
   logic unused_bypass;
   assign unused_bypass = ^{wr_ok, w_addr, w_data, w_be};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid_reg <= 1'b0;
         r_data_reg  <= '0;
      end else begin
         r_valid_reg <= r_en && active;
         if (r_en && active) begin
            r_data_reg <= word;
         end
      end
   end

   assign r_data  = r_data_reg;
   assign r_valid = r_valid_reg;

endmodule

// File: rtl/byte_mem_2r1w.sv
// Byte-addressed memory, 2 read ports + 1 write port, unaligned big-endian words with wrap,
// zeroed by a CLEAR pass after reset or on request. Optional bypass: BYTE_MEM_BYPASS_EN.
module byte_mem_2r1w
   import byte_mem_pkg::*;
#(
   parameter int B  = DEFAULT_B,
   parameter int N  = DEFAULT_N,
   parameter int WB = DEFAULT_WB
) (
   input  logic         clk,
   input  logic         rst_n,
   byte_mem_if.slave    bus
);

   localparam int WL   = $clog2(WB);
   localparam int RW   = N - WL;
   localparam int ROWS = 2 ** RW;

   state_t               state_reg;
   logic [RW-1:0]        clr_ptr_reg;
   logic                 clearing;
   logic                 active;
   logic                 wr_ok;
   logic [WB-1:0][RW-1:0] rd1_row, rd2_row;
   logic [WB-1:0][B-1:0]  rd1_bytes, rd2_bytes, w_bytes;

   assign clearing = (state_reg == CLEAR);
   assign active   = (state_reg == READY);
   assign wr_ok    = active && bus.w_en && !bus.clr_req;
   assign bus.busy = clearing;
   assign w_bytes  = bus.w_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= CLEAR;
         clr_ptr_reg <= '0;
      end else begin
         case (state_reg)
            CLEAR: begin
               clr_ptr_reg <= clr_ptr_reg + 1'b1;
               if (&clr_ptr_reg) begin
                  state_reg <= READY;
               end
            end
            READY: begin
               if (bus.clr_req) begin
                  state_reg   <= CLEAR;
                  clr_ptr_reg <= '0;
               end
            end
            default: state_reg <= CLEAR;
         endcase
      end
   end

   // Bank gi holds every byte whose address is congruent to gi modulo WB.
   genvar gi;
   generate
      for (gi = 0; gi < WB; gi++) begin : g_bank
         logic [B-1:0]  mem [ROWS];
         logic [WL-1:0] k;
         logic [RW-1:0] w_row;

         assign k     = WL'(gi) - bus.w_addr[WL-1:0];
         assign w_row = bus.w_addr[N-1:WL] + RW'(WL'(gi) < bus.w_addr[WL-1:0]);

         always_ff @(posedge clk) begin
            if (clearing) begin
               mem[clr_ptr_reg] <= '0;
            end else if (wr_ok && bus.w_be[~k]) begin
               mem[w_row] <= w_bytes[~k];
            end
         end

         assign rd1_bytes[gi] = mem[rd1_row[gi]];
         assign rd2_bytes[gi] = mem[rd2_row[gi]];
      end
   endgenerate

   byte_mem_rd_port #(.B(B), .N(N), .WB(WB)) u_rd1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .active     (active),
      .r_en       (bus.r_en1),
      .r_addr     (bus.r_addr1),
      .bank_row   (rd1_row),
      .bank_rdata (rd1_bytes),
      .wr_ok      (wr_ok),
      .w_addr     (bus.w_addr),
      .w_data     (bus.w_data),
      .w_be       (bus.w_be),
      .r_data     (bus.r_data1),
      .r_valid    (bus.r_valid1)
   );

   byte_mem_rd_port #(.B(B), .N(N), .WB(WB)) u_rd2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .active     (active),
      .r_en       (bus.r_en2),
      .r_addr     (bus.r_addr2),
      .bank_row   (rd2_row),
      .bank_rdata (rd2_bytes),
      .wr_ok      (wr_ok),
      .w_addr     (bus.w_addr),
      .w_data     (bus.w_data),
      .w_be       (bus.w_be),
      .r_data     (bus.r_data2),
      .r_valid    (bus.r_valid2)
   );

endmodule

// File: tb/tb_byte_mem_2r1w.sv
// Directed bench for byte_mem_2r1w (B=8, N=10, WB=4); expectations follow BYTE_MEM_BYPASS_EN.
module tb_byte_mem_2r1w;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   byte_mem_if #(.B(8), .N(10), .WB(4)) bus ();

   byte_mem_2r1w #(.B(8), .N(10), .WB(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

`ifdef BYTE_MEM_BYPASS_EN
   localparam logic [31:0] EXP_SAME_20 = 32'hDEADBEEF;
   localparam logic [31:0] EXP_SAME_1E = 32'h0000DEAD;
`else
   localparam logic [31:0] EXP_SAME_20 = 32'h00000000;
   localparam logic [31:0] EXP_SAME_1E = 32'h00000000;
`endif

   typedef struct {
      logic        w_en;
      logic [9:0]  w_addr;
      logic [31:0] w_data;
      logic [3:0]  w_be;
      logic        r_en1;
      logic [9:0]  r_addr1;
      logic        r_en2;
      logic [9:0]  r_addr2;
      logic        exp_v1;
      logic [31:0] exp_d1;
      logic        exp_v2;
      logic [31:0] exp_d2;
   } vec_t;

   vec_t vecs[13];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [9:0] wa, input logic [31:0] wd,
                               input logic [3:0] be, input logic re1, input logic [9:0] ra1,
                               input logic re2, input logic [9:0] ra2, input logic v1,
                               input logic [31:0] d1, input logic v2, input logic [31:0] d2);
      vec_t v;
      v.w_en = we;  v.w_addr = wa;   v.w_data = wd;  v.w_be = be;
      v.r_en1 = re1; v.r_addr1 = ra1; v.r_en2 = re2; v.r_addr2 = ra2;
      v.exp_v1 = v1; v.exp_d1 = d1;  v.exp_v2 = v2;  v.exp_d2 = d2;
      return v;
   endfunction

   task automatic idle_inputs();
      bus.clr_req = 1'b0;
      bus.w_en = 1'b0; bus.w_addr = '0; bus.w_data = '0; bus.w_be = '0;
      bus.r_en1 = 1'b0; bus.r_addr1 = '0; bus.r_en2 = 1'b0; bus.r_addr2 = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(output int n, output logic saw_valid);
      n = 0;
      saw_valid = 1'b0;
      while (bus.busy === 1'b1 && n < 1000) begin
         step();
         n++;
         if (bus.r_valid1 !== 1'b0 || bus.r_valid2 !== 1'b0) saw_valid = 1'b1;
      end
   endtask

   task automatic read1(input logic [9:0] a);
      idle_inputs();
      bus.r_en1 = 1'b1; bus.r_addr1 = a;
      step();
      idle_inputs();
   endtask

   initial begin
      int       n;
      logic     sv;
      idle_inputs();

      // Reset asserted: outputs forced before any clock edge.
      #3;
      chk("rst_busy", 32'(bus.busy), 32'd1);
      chk("rst_valid1", 32'(bus.r_valid1), 32'd0);
      chk("rst_valid2", 32'(bus.r_valid2), 32'd0);
      chk("rst_data1", bus.r_data1, 32'h0);
      chk("rst_data2", bus.r_data2, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_ready(n, sv);
      chk("init_clear_cycles", 32'(n), 32'd256);
      $display("init clear: busy for %0d cycles", n);

      vecs[0]  = mk(0, 10'h000, 32'h0,        4'h0, 1, 10'h3FC, 0, 10'h000, 1, 32'h00000000, 0, 32'h00000000);
      vecs[1]  = mk(1, 10'h3FE, 32'h11223344, 4'hF, 0, 10'h000, 0, 10'h000, 0, 32'h00000000, 0, 32'h00000000);
      vecs[2]  = mk(0, 10'h000, 32'h0,        4'h0, 1, 10'h3FE, 1, 10'h000, 1, 32'h11223344, 1, 32'h33440000);
      vecs[3]  = mk(0, 10'h000, 32'h0,        4'h0, 1, 10'h3FF, 1, 10'h001, 1, 32'h22334400, 1, 32'h44000000);
      vecs[4]  = mk(1, 10'h010, 32'hAABBCCDD, 4'hF, 0, 10'h000, 0, 10'h000, 0, 32'h22334400, 0, 32'h44000000);
      vecs[5]  = mk(1, 10'h010, 32'h00000000, 4'h5, 0, 10'h000, 0, 10'h000, 0, 32'h22334400, 0, 32'h44000000);
      vecs[6]  = mk(0, 10'h000, 32'h0,        4'h0, 1, 10'h010, 1, 10'h012, 1, 32'hAA00CC00, 1, 32'hCC000000);
      vecs[7]  = mk(1, 10'h010, 32'hFFFFFFFF, 4'h0, 0, 10'h000, 0, 10'h000, 0, 32'hAA00CC00, 0, 32'hCC000000);
      vecs[8]  = mk(0, 10'h000, 32'h0,        4'h0, 1, 10'h010, 1, 10'h010, 1, 32'hAA00CC00, 1, 32'hAA00CC00);
      vecs[9]  = mk(1, 10'h020, 32'hDEADBEEF, 4'hF, 1, 10'h01E, 1, 10'h020, 1, EXP_SAME_1E,  1, EXP_SAME_20);
      vecs[10] = mk(0, 10'h000, 32'h0,        4'h0, 1, 10'h022, 1, 10'h020, 1, 32'hBEEF0000, 1, 32'hDEADBEEF);
      vecs[11] = mk(1, 10'h021, 32'h01020304, 4'hA, 0, 10'h000, 0, 10'h000, 0, 32'hBEEF0000, 0, 32'hDEADBEEF);
      vecs[12] = mk(0, 10'h000, 32'h0,        4'h0, 1, 10'h020, 1, 10'h3FD, 1, 32'hDE01BE03, 1, 32'h00112233);

      for (int i = 0; i < 13; i++) begin
         bus.w_en = vecs[i].w_en;   bus.w_addr = vecs[i].w_addr;
         bus.w_data = vecs[i].w_data; bus.w_be = vecs[i].w_be;
         bus.r_en1 = vecs[i].r_en1; bus.r_addr1 = vecs[i].r_addr1;
         bus.r_en2 = vecs[i].r_en2; bus.r_addr2 = vecs[i].r_addr2;
         step();
         $display("vec %0d: r1 %b/0x%08h r2 %b/0x%08h", i,
                  bus.r_valid1, bus.r_data1, bus.r_valid2, bus.r_data2);
         chk($sformatf("vec%0d_valid1", i), 32'(bus.r_valid1), 32'(vecs[i].exp_v1));
         chk($sformatf("vec%0d_data1", i), bus.r_data1, vecs[i].exp_d1);
         chk($sformatf("vec%0d_valid2", i), 32'(bus.r_valid2), 32'(vecs[i].exp_v2));
         chk($sformatf("vec%0d_data2", i), bus.r_data2, vecs[i].exp_d2);
      end
      idle_inputs();

      // Clear request with a simultaneous write; reads while busy must not be valid.
      bus.clr_req = 1'b1;
      bus.w_en = 1'b1; bus.w_addr = 10'h040; bus.w_data = 32'h12345678; bus.w_be = 4'hF;
      step();
      idle_inputs();
      chk("clr_busy", 32'(bus.busy), 32'd1);
      bus.r_en1 = 1'b1; bus.r_addr1 = 10'h020;
      bus.r_en2 = 1'b1; bus.r_addr2 = 10'h020;
      wait_ready(n, sv);
      idle_inputs();
      $display("clr_req clear: busy for %0d cycles", n);
      chk("clr_cycles", 32'(n), 32'd256);
      chk("clr_valid_while_busy", 32'(sv), 32'd0);
      chk("clr_data1_held", bus.r_data1, 32'hDE01BE03);
      read1(10'h040);
      chk("clr_write_dropped", bus.r_data1, 32'h00000000);
      chk("clr_write_dropped_v", 32'(bus.r_valid1), 32'd1);
      read1(10'h020);
      chk("clr_zeroed_20", bus.r_data1, 32'h00000000);

      // Reset in the middle of a clear pass.
      bus.w_en = 1'b1; bus.w_addr = 10'h050; bus.w_data = 32'hCAFEF00D; bus.w_be = 4'hF;
      step();
      read1(10'h050);
      chk("pre_rst_data", bus.r_data1, 32'hCAFEF00D);
      bus.clr_req = 1'b1;
      step();
      idle_inputs();
      repeat (100) step();
      chk("mid_clear_busy", 32'(bus.busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_valid1", 32'(bus.r_valid1), 32'd0);
      chk("midrst_data1", bus.r_data1, 32'h0);
      chk("midrst_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      wait_ready(n, sv);
      $display("post-reset clear: busy for %0d cycles", n);
      chk("midrst_clear_cycles", 32'(n), 32'd256);
      read1(10'h050);
      chk("midrst_zeroed_50", bus.r_data1, 32'h00000000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
